// File: rtl/s2p_align_rx_pkg.sv
// Shared constants and state type for the serial-to-parallel lane aligner.
// The p2s idle-insert path draws its idle symbol from here as well.
package s2p_align_rx_pkg;

  localparam int          LANES   = 4;
  localparam logic [7:0]  COM_SYM = 8'hBC;

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } lane_state_t;

endpackage

// File: rtl/s2p_align_rx_if.sv
// Serial lane input and aligned byte output bundle for s2p_align_rx.
// The slave side is the aligner and the master side is whoever drives the lanes.
interface s2p_align_rx_if;
  import s2p_align_rx_pkg::*;

  logic             IN_ENB_s2p;
  logic [LANES-1:0] IN_LANE_s2p;
  logic [7:0]       OUT_LANE3_s2p;
  logic [7:0]       OUT_LANE2_s2p;
  logic [7:0]       OUT_LANE1_s2p;
  logic [7:0]       OUT_LANE0_s2p;
  logic [LANES-1:0] OUT_VALID_s2p;
  logic [LANES-1:0] OUT_LOCK_s2p;
  logic             OUT_ALL_LOCK;

  modport master (
    output IN_ENB_s2p, IN_LANE_s2p,
    input  OUT_LANE3_s2p, OUT_LANE2_s2p, OUT_LANE1_s2p, OUT_LANE0_s2p,
    input  OUT_VALID_s2p, OUT_LOCK_s2p, OUT_ALL_LOCK
  );

  modport slave (
    input  IN_ENB_s2p, IN_LANE_s2p,
    output OUT_LANE3_s2p, OUT_LANE2_s2p, OUT_LANE1_s2p, OUT_LANE0_s2p,
    output OUT_VALID_s2p, OUT_LOCK_s2p, OUT_ALL_LOCK
  );

endinterface

// File: rtl/s2p_align_rx_lane_align.sv
// One-lane byte aligner: finds the COM boundary in the bit stream, confirms it
// over consecutive COM bytes, then delivers every following byte in parallel.
module s2p_lane_align
  import s2p_align_rx_pkg::*;
#(
  parameter logic [7:0] COM      = COM_SYM,
  parameter int         LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enb,
  input  logic       serial_bit,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       lane_lock,
  output logic       lock_next
);

  localparam logic [2:0] LOCK_TARGET = 3'(LOCK_CNT);

  lane_state_t state;
  logic [7:0]  sr;
  logic [7:0]  byte_next;
  logic [2:0]  bc;
  logic [2:0]  cc;
  logic        com_seen;
  logic        boundary;

  assign byte_next = {sr[6:0], serial_bit};
  assign com_seen  = (byte_next == COM);
  assign boundary  = (bc == 3'd7);

  // Exported so the top can register the all-lanes lock on the same edge as the lanes.
  assign lock_next = enb &&
                     ((state == S_LOCKED) ||
                      (state == S_SEARCH  && com_seen && LOCK_CNT == 1) ||
                      (state == S_CONFIRM && boundary && com_seen && (cc + 3'd1) == LOCK_TARGET));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SEARCH;
      sr         <= 8'h00;
      bc         <= 3'd0;
      cc         <= 3'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      lane_lock  <= 1'b0;
    end else begin
      sr         <= byte_next;
      lane_lock  <= lock_next;
      byte_valid <= 1'b0;
      if (!enb) begin
        state <= S_SEARCH;
        cc    <= 3'd0;
        bc    <= 3'd0;
      end else begin
        case (state)
          S_SEARCH: begin
            if (com_seen) begin
              bc    <= 3'd0;
              cc    <= 3'd1;
              state <= (LOCK_CNT == 1) ? S_LOCKED : S_CONFIRM;
            end
          end
          S_CONFIRM: begin
            bc <= bc + 3'd1;
            if (boundary) begin
              if (com_seen) begin
                cc <= cc + 3'd1;
                if ((cc + 3'd1) == LOCK_TARGET) state <= S_LOCKED;
              end else begin
                cc    <= 3'd0;
                state <= S_SEARCH;
              end
            end
          end
          S_LOCKED: begin
            bc <= bc + 3'd1;
            // COM bytes still update the held byte; they just never strobe valid.
            if (boundary) begin
              byte_out   <= byte_next;
              byte_valid <= !com_seen;
            end
          end
          default: state <= S_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: rtl/s2p_align_rx.sv
// Four-lane receive aligner: one independent s2p_lane_align per serial lane
// plus the registered all-lanes-locked flag.
module s2p_align_rx
  import s2p_align_rx_pkg::*;
#(
  parameter logic [7:0] COM      = COM_SYM,
  parameter int         LOCK_CNT = 2
) (
  input  logic               IN_CLK_s2p,
  input  logic               IN_RESET_s2p,
  s2p_align_rx_if.slave      bus
);

  logic [7:0]       lane_byte [LANES];
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_lock;
  logic [LANES-1:0] lock_next;
  logic             all_lock;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    s2p_lane_align #(
      .COM      (COM),
      .LOCK_CNT (LOCK_CNT)
    ) u_lane (
      .clk        (IN_CLK_s2p),
      .rst_n      (IN_RESET_s2p),
      .enb        (bus.IN_ENB_s2p),
      .serial_bit (bus.IN_LANE_s2p[i]),
      .byte_out   (lane_byte[i]),
      .byte_valid (lane_valid[i]),
      .lane_lock  (lane_lock[i]),
      .lock_next  (lock_next[i])
    );
  end

  // Built from the lanes' next-lock terms so it rises on the same edge as the last lane.
  always_ff @(posedge IN_CLK_s2p or negedge IN_RESET_s2p) begin
    if (!IN_RESET_s2p) all_lock <= 1'b0;
    else               all_lock <= &lock_next;
  end

  assign bus.OUT_LANE0_s2p = lane_byte[0];
  assign bus.OUT_LANE1_s2p = lane_byte[1];
  assign bus.OUT_LANE2_s2p = lane_byte[2];
  assign bus.OUT_LANE3_s2p = lane_byte[3];
  assign bus.OUT_VALID_s2p = lane_valid;
  assign bus.OUT_LOCK_s2p  = lane_lock;
  assign bus.OUT_ALL_LOCK  = all_lock;

endmodule
